// File: rtl/serial_arith_pkg.sv
// ---------------------------------------------------------------------------
// serial_arith_pkg
// Shared types and constants for the bit-serial arithmetic cells.
//   ser_state_e        : control state of the serial subtractor (IDLE/SHIFT/DONE)
//   SER_WIDTH_DEFAULT  : default operand width in bits
// ---------------------------------------------------------------------------
package serial_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } ser_state_e;

  localparam int SER_WIDTH_DEFAULT = 8;

endpackage : serial_arith_pkg

// File: rtl/full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
// One-bit full subtractor cell: computes x - y - bin.
//   x    : minuend bit
//   y    : subtrahend bit
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out (1 when x < y + bin)
// Purely combinational.
// ---------------------------------------------------------------------------
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic xy_diff_s;

  // Difference and borrow generation for a single bit position.
  always_comb begin
    xy_diff_s = x ^ y;
    d         = xy_diff_s ^ bin;
    // Borrow when x=0,y=1, or when x==y and a borrow is already pending.
    bout      = (~x & y) | (~xy_diff_s & bin);
  end

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial WIDTH-bit subtractor: diff = a - b - borrow_in (mod 2^WIDTH),
// processed LSB first, one bit per clock, using a single full_subtractor cell.
//   clk, rst    : clock, asynchronous active-high reset
//   in_valid    : operands a, b, borrow_in valid
//   in_ready    : block can accept operands (only while idle)
//   a, b        : minuend, subtrahend
//   borrow_in   : initial borrow
//   out_valid   : diff / borrow_out valid
//   out_ready   : consumer accepts the result
//   diff        : a - b - borrow_in modulo 2^WIDTH
//   borrow_out  : 1 iff a < b + borrow_in (unsigned)
// Latency from accept edge to out_valid is exactly WIDTH cycles.
// ---------------------------------------------------------------------------
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             cell_d_s;
  logic             cell_bout_s;

  full_subtractor u_cell (
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0]),
    .bin  (borrow_q),
    .d    (cell_d_s),
    .bout (cell_bout_s)
  );

  // Next-state and datapath update for the serial subtract sequence.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = borrow_in;
          cnt_d    = {CW{1'b0}};
          state_d  = ST_SHIFT;
        end else begin
          state_d  = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        // Result bits arrive LSB first, so insert at the MSB and shift down;
        // after WIDTH shifts the first bit lands in position 0.
        diff_d   = {cell_d_s, diff_q[WIDTH-1:1]};
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        borrow_d = cell_bout_s;
        if (cnt_q == LAST_CNT) begin
          bout_d  = cell_bout_s;
          cnt_d   = {CW{1'b0}};
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          state_d = ST_SHIFT;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= {WIDTH{1'b0}};
      b_sh_q   <= {WIDTH{1'b0}};
      borrow_q <= 1'b0;
      cnt_q    <= {CW{1'b0}};
      diff_q   <= {WIDTH{1'b0}};
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  // Handshake flags are decoded straight from the state register.
  always_comb begin
    in_ready   = (state_q == ST_IDLE);
    out_valid  = (state_q == ST_DONE);
    diff       = diff_q;
    borrow_out = bout_q;
  end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
// Self-checking bench: standalone cell check, table-driven vectors on the
// default-width block, hand-written back-pressure / reset / back-to-back
// sequences, and WIDTH=2 / WIDTH=16 instances.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Default-width instance
  logic       in_valid = 1'b0, in_ready, borrow_in = 1'b0;
  logic [7:0] a = 8'h00, b = 8'h00, diff;
  logic       out_valid, out_ready = 1'b1, borrow_out;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .borrow_in(borrow_in), .out_valid(out_valid),
    .out_ready(out_ready), .diff(diff), .borrow_out(borrow_out)
  );

  // WIDTH=2 instance
  logic       in_valid_w2 = 1'b0, in_ready_w2, borrow_in_w2 = 1'b0;
  logic [1:0] a_w2 = 2'd0, b_w2 = 2'd0, diff_w2;
  logic       out_valid_w2, out_ready_w2 = 1'b1, borrow_out_w2;

  serial_subtractor #(.WIDTH(2)) dut_w2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_w2), .in_ready(in_ready_w2),
    .a(a_w2), .b(b_w2), .borrow_in(borrow_in_w2), .out_valid(out_valid_w2),
    .out_ready(out_ready_w2), .diff(diff_w2), .borrow_out(borrow_out_w2)
  );

  // WIDTH=16 instance
  logic        in_valid_w16 = 1'b0, in_ready_w16, borrow_in_w16 = 1'b0;
  logic [15:0] a_w16 = 16'd0, b_w16 = 16'd0, diff_w16;
  logic        out_valid_w16, out_ready_w16 = 1'b1, borrow_out_w16;

  serial_subtractor #(.WIDTH(16)) dut_w16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_w16), .in_ready(in_ready_w16),
    .a(a_w16), .b(b_w16), .borrow_in(borrow_in_w16), .out_valid(out_valid_w16),
    .out_ready(out_ready_w16), .diff(diff_w16), .borrow_out(borrow_out_w16)
  );

  // Standalone cell
  logic fx = 1'b0, fy = 1'b0, fbin = 1'b0, fd, fbout;
  full_subtractor u_fs (.x(fx), .y(fy), .bin(fbin), .d(fd), .bout(fbout));

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] exp_diff;
    logic       exp_bout;
  } vec_t;

  vec_t vecs[10];

  // Issue one operation on the 8-bit instance from a negedge; returns the
  // result seen while out_valid and the number of edges from accept.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                        output logic [7:0] rd, output logic rb, output int lat);
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    a = ta; b = tb_v; borrow_in = tbin; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 64) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
    if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
    rd = diff;
    rb = borrow_out;
  endtask

  initial begin
    logic [7:0] rd;
    logic       rb;
    int         lat;
    int         acc_prev;
    int         acc_now;
    logic [8:0] ref9;

    // Full-subtractor cell, all 8 input combinations
    for (int i = 0; i < 8; i++) begin
      int r;
      {fx, fy, fbin} = 3'(i);
      #1;
      r = int'(fx) - int'(fy) - int'(fbin);
      chk($sformatf("cell_d_%0d", i), 32'(fd), 32'(r & 1));
      chk($sformatf("cell_bout_%0d", i), 32'(fbout), (r < 0) ? 32'd1 : 32'd0);
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow_out", 32'(borrow_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'h80, 8'h80, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[7] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0};
    vecs[8] = '{8'h37, 8'h59, 1'b0, 8'hDE, 1'b1};
    vecs[9] = '{8'hC8, 8'h64, 1'b1, 8'h63, 1'b0};

    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, rd, rb, lat);
      chk($sformatf("vec%0d_diff", i), 32'(rd), 32'(vecs[i].exp_diff));
      chk($sformatf("vec%0d_bout", i), 32'(rb), 32'(vecs[i].exp_bout));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
      @(negedge clk);
      chk($sformatf("vec%0d_back_idle", i), 32'(in_ready), 32'd1);
    end

    // Back-pressure: result must hold while out_ready is low
    out_ready = 1'b0;
    run_op(8'hC8, 8'h64, 1'b0, rd, rb, lat);
    for (int k = 0; k < 5; k++) begin
      a = 8'hAA; b = 8'h11; borrow_in = 1'b1; in_valid = (k % 2 == 0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_diff", 32'(diff), 32'h64);
      chk("bp_bout", 32'(borrow_out), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp_diff_final", 32'(diff), 32'h64);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_idle", 32'(in_ready), 32'd1);
    chk("bp_release_diff_kept", 32'(diff), 32'h64);

    // Reset in the middle of SHIFT
    a = 8'h5A; b = 8'h3C; borrow_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_diff", 32'(diff), 32'd0);
    chk("midrst_bout", 32'(borrow_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_no_output", 32'(out_valid), 32'd0);
    run_op(8'h10, 8'h01, 1'b0, rd, rb, lat);
    chk("postrst_diff", 32'(rd), 32'h0F);
    chk("postrst_bout", 32'(rb), 32'd0);
    chk("postrst_latency", 32'(lat), 32'd8);
    @(negedge clk);

    // Back-to-back: in_valid and out_ready held high
    acc_prev = 0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      borrow_in = 1'($urandom_range(0, 1));
      ref9 = {1'b0, a} - {1'b0, b} - {8'h00, borrow_in};
      chk($sformatf("b2b%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 acc_now = cyc;
      if (i > 0) chk($sformatf("b2b%0d_spacing", i), 32'(acc_now - acc_prev), 32'd10);
      acc_prev = acc_now;
      lat = 0;
      while (lat < 64) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
        if (out_valid) break;
      end
      chk($sformatf("b2b%0d_latency", i), 32'(lat), 32'd8);
      chk($sformatf("b2b%0d_diff", i), 32'(diff), 32'(ref9[7:0]));
      chk($sformatf("b2b%0d_bout", i), 32'(borrow_out), 32'(ref9[8]));
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);

    // WIDTH=2: 0 - 3 - 1 wraps to 0 with borrow
    a_w2 = 2'd0; b_w2 = 2'd3; borrow_in_w2 = 1'b1; in_valid_w2 = 1'b1;
    @(posedge clk);
    #1 in_valid_w2 = 1'b0;
    lat = 0;
    while (lat < 64) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid_w2) break;
    end
    chk("w2_latency", 32'(lat), 32'd2);
    chk("w2_diff", 32'(diff_w2), 32'd0);
    chk("w2_bout", 32'(borrow_out_w2), 32'd1);
    @(negedge clk);

    // WIDTH=16: 0 - FFFF - 1 wraps to 0 with borrow
    a_w16 = 16'h0000; b_w16 = 16'hFFFF; borrow_in_w16 = 1'b1; in_valid_w16 = 1'b1;
    @(posedge clk);
    #1 in_valid_w16 = 1'b0;
    lat = 0;
    while (lat < 64) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid_w16) break;
    end
    chk("w16_latency", 32'(lat), 32'd16);
    chk("w16_diff", 32'(diff_w16), 32'd0);
    chk("w16_bout", 32'(borrow_out_w16), 32'd1);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_serial_subtractor
